actel_cfg_loader: RTL and testbench

//   Serial configuration writer for an array of Actel S2 logic cells.

---
 rtl/actel_cfg_loader.sv | 146 ++++++++++++++
 tb/tb_actel_cfg_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/actel_cfg_loader.sv
// actel_cfg_loader: serial configuration writer for an array of Actel S2
// logic cells. Shifts in one config bit per valid/ready handshake, then
// publishes the assembled frame on a parallel bus with a one-cycle strobe.
module actel_cfg_loader #(
  parameter int NUM_CELLS = 4,
  parameter int CFG_W     = 4
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic                       start,
  input  logic                       cfg_valid,
  input  logic                       cfg_bit,
  output logic                       cfg_ready,
  output logic [NUM_CELLS*CFG_W-1:0] cfg_bus,
  output logic                       cfg_load,
  output logic                       busy,
  output logic                       done
);

  localparam int TOTAL = NUM_CELLS * CFG_W;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TOTAL-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TOTAL-1:0]   cfgBus_q, cfgBus_d;
  logic               done_q, done_d;

  logic               accept;
  logic               lastAccept;
  logic [TOTAL-1:0]   shiftedWord;

  // A bit is taken only while shifting and the frame is not yet full;
  // the full-count guard keeps the counter from ever passing TOTAL.
  assign accept      = (state_q == SHIFT) && cfg_valid && (count_q != FULL_CNT);
  assign lastAccept  = accept && (count_q == LAST_CNT);
  assign shiftedWord = {shreg_q[TOTAL-2:0], cfg_bit};

  // State register; CLR returns to IDLE from anywhere, dropping a partial frame.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE waits for start, SHIFT waits for the final bit, LOAD lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (lastAccept) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded directly from the state.
  always_comb begin
    cfg_ready = 1'b0;
    cfg_load  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b0;
      end
      SHIFT: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
      end
      LOAD: begin
        cfg_load  = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        cfg_ready = 1'b0;
      end
    endcase
  end

  // Datapath next values. The bus is written on the edge that enters LOAD so
  // that the new word and the load strobe appear together in the LOAD cycle.
  always_comb begin
    shreg_d  = shreg_q;
    count_d  = count_q;
    cfgBus_d = cfgBus_q;
    done_d   = done_q;
    if (state_q == IDLE && start) begin
      shreg_d = '0;
      count_d = '0;
      done_d  = 1'b0;
    end
    if (accept) begin
      shreg_d = shiftedWord;
      count_d = count_q + CNT_ONE;
    end
    if (lastAccept) begin
      cfgBus_d = shiftedWord;
    end
    if (state_q == LOAD) begin
      done_d = 1'b1;
    end
  end

  // Datapath registers; CLR clears the published bus as well as the frame in progress.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      shreg_q  <= '0;
      count_q  <= '0;
      cfgBus_q <= '0;
      done_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      cfgBus_q <= cfgBus_d;
      done_q   <= done_d;
    end
  end

  assign cfg_bus = cfgBus_q;
  assign done    = done_q;

endmodule

// File: tb/tb_actel_cfg_loader.sv
// Directed self-checking bench for actel_cfg_loader (4 cells x 4 bits).
module tb_actel_cfg_loader;

  localparam int TOTAL = 16;

  logic             CLK = 1'b0;
  logic             CLR;
  logic             start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_ready;
  logic [TOTAL-1:0] cfg_bus;
  logic             cfg_load;
  logic             busy;
  logic             done;

  int checks = 0;
  int passes = 0;

  actel_cfg_loader #(.NUM_CELLS(4), .CFG_W(4)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .start     (start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_bus   (cfg_bus),
    .cfg_load  (cfg_load),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time units per period.
  always #5 CLK = ~CLK;

  // Advance one rising edge; outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Pulse start in IDLE and confirm the loader is now shifting with done cleared.
  task automatic startFrame(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, "_readyAfterStart"}, 32'(cfg_ready), 32'd1);
    checkOutput({tag, "_doneCleared"}, 32'(done), 32'd0);
  endtask

  // Send a full frame MSB first, optionally with an idle cycle before each bit
  // and optionally pulsing start alongside the 8th bit.
  task automatic applyStimulus(input string tag, input logic [TOTAL-1:0] word,
                               input logic [TOTAL-1:0] prevBus, input bit gapped,
                               input bit midStart);
    int readyCycles;
    readyCycles = 0;
    for (int i = TOTAL - 1; i >= 0; i--) begin
      if (gapped) begin
        cfg_valid = 1'b0;
        if (cfg_ready) readyCycles++;
        tick();
      end
      cfg_valid = 1'b1;
      cfg_bit   = word[i];
      start     = midStart && (i == TOTAL - 8);
      if (cfg_ready) readyCycles++;
      if (i == 0) begin
        checkOutput({tag, "_busHeldBeforeLoad"}, 32'(cfg_bus), 32'(prevBus));
        checkOutput({tag, "_noLoadYet"}, 32'(cfg_load), 32'd0);
      end
      tick();
      start = 1'b0;
    end
    checkOutput({tag, "_readyCycles"}, 32'(readyCycles), gapped ? 32'd32 : 32'd16);
    checkOutput({tag, "_loadStrobe"}, 32'(cfg_load), 32'd1);
    checkOutput({tag, "_busAtLoad"}, 32'(cfg_bus), 32'(word));
    checkOutput({tag, "_busyInLoad"}, 32'(busy), 32'd1);
    checkOutput({tag, "_readyInLoad"}, 32'(cfg_ready), 32'd0);
    tick();
    cfg_valid = 1'b0;
    checkOutput({tag, "_loadOneCycle"}, 32'(cfg_load), 32'd0);
    checkOutput({tag, "_doneSet"}, 32'(done), 32'd1);
    checkOutput({tag, "_idleNotBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_busHeldAfter"}, 32'(cfg_bus), 32'(word));
  endtask

  initial begin
    CLR       = 1'b1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    @(negedge CLK);

    // Test 1: reset for two cycles, then release.
    tick();
    tick();
    CLR = 1'b0;
    tick();
    checkOutput("rst_ready", 32'(cfg_ready), 32'd0);
    checkOutput("rst_bus", 32'(cfg_bus), 32'd0);
    checkOutput("rst_load", 32'(cfg_load), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    // cfg_valid in IDLE is ignored.
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    tick();
    cfg_valid = 1'b0;
    checkOutput("idle_validIgnoredReady", 32'(cfg_ready), 32'd0);
    checkOutput("idle_validIgnoredBus", 32'(cfg_bus), 32'd0);

    // Test 2: frame 0110 x4, cfg_valid held high.
    startFrame("t2");
    applyStimulus("t2", 16'h6666, 16'h0000, 1'b0, 1'b0);

    // Test 3: same frame with cfg_valid toggling.
    startFrame("t3");
    checkOutput("t3_busHeldAtStart", 32'(cfg_bus), 32'h6666);
    applyStimulus("t3", 16'h6666, 16'h6666, 1'b1, 1'b0);

    // Test 4: start pulsed after 7 bits must not restart the frame.
    startFrame("t4");
    applyStimulus("t4", 16'h9A3C, 16'h6666, 1'b0, 1'b1);

    // Test 5: CLR after 9 bits discards the partial frame and clears the bus.
    startFrame("t5");
    for (int i = 0; i < 9; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = i[0];
      tick();
    end
    cfg_valid = 1'b0;
    CLR       = 1'b1;
    start     = 1'b1;
    tick();
    CLR   = 1'b0;
    start = 1'b0;
    checkOutput("t5_clrBus", 32'(cfg_bus), 32'd0);
    checkOutput("t5_clrReady", 32'(cfg_ready), 32'd0);
    checkOutput("t5_clrBusy", 32'(busy), 32'd0);
    checkOutput("t5_clrDone", 32'(done), 32'd0);
    startFrame("t5b");
    applyStimulus("t5b", 16'hA5C3, 16'h0000, 1'b0, 1'b0);
    checkOutput("t5_cell0", 32'(cfg_bus[3:0]), 32'h3);
    checkOutput("t5_cell3", 32'(cfg_bus[15:12]), 32'hA);

    // Test 6: back-to-back frames, start the cycle after done.
    startFrame("t6a");
    checkOutput("t6_busHeldAtStart", 32'(cfg_bus), 32'hA5C3);
    applyStimulus("t6a", 16'h1234, 16'hA5C3, 1'b0, 1'b0);
    startFrame("t6b");
    applyStimulus("t6b", 16'hBEEF, 16'h1234, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
